rob_commit_unit: RTL

// - Reorder buffer feeding the register file's rename/commit interface. Allocates ROB tags to decoded

---
 rtl/rob_commit_unit_pkg.sv | 31 +++
 rtl/rob_commit_unit_if.sv | 43 ++++
 rtl/rob_commit_unit_rob_ptr.sv | 36 +++
 rtl/rob_commit_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rob_commit_unit_pkg.sv
// Shared types and sizing for the reorder-buffer commit unit.
// Tags are 1..ROB_SIZE; tag 0 (TAG_NONE) means "no producer".
package rob_commit_unit_pkg;

  localparam int ROB_SIZE      = 8;
  localparam int ROB_SIZE_BITS = 3;
  localparam int TAG_W         = ROB_SIZE_BITS + 1;
  localparam int RD_W          = 5;
  localparam int DATA_W        = 32;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t TAG_NONE  = '0;
  localparam tag_t TAG_FIRST = tag_t'(1);
  localparam tag_t TAG_LAST  = tag_t'(ROB_SIZE);

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              wen;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              mispredict;
  } rob_entry_t;

  // Next tag in program order; wraps ROB_SIZE back to 1, skipping tag 0.
  function automatic tag_t tag_next(input tag_t t);
    return (t == TAG_LAST) ? TAG_FIRST : t + tag_t'(1);
  endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// Decode allocation, CDB broadcast and commit/rename write bus of the ROB.
// master = pipeline side (decode, CDB source, register file); slave = the ROB.
interface rob_commit_unit_if;
  import rob_commit_unit_pkg::*;

  logic              alloc_valid;
  logic              alloc_wen;
  logic [RD_W-1:0]   alloc_rd;
  logic              alloc_ready;
  tag_t              alloc_roben;

  logic              Decoded_WP1_Wen;
  tag_t              Decoded_WP1_ROBEN;
  logic [RD_W-1:0]   Decoded_WP1_DRindex;

  logic              cdb_valid;
  tag_t              cdb_roben;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_mispredict;

  logic              WP1_Wen;
  tag_t              WP1_ROBEN;
  logic [RD_W-1:0]   WP1_DRindex;
  logic [DATA_W-1:0] WP1_Data;
  logic              ROB_FLUSH_Flag;

  modport master (
    output alloc_valid, alloc_wen, alloc_rd,
    input  alloc_ready, alloc_roben,
    input  Decoded_WP1_Wen, Decoded_WP1_ROBEN, Decoded_WP1_DRindex,
    output cdb_valid, cdb_roben, cdb_data, cdb_mispredict,
    input  WP1_Wen, WP1_ROBEN, WP1_DRindex, WP1_Data, ROB_FLUSH_Flag
  );

  modport slave (
    input  alloc_valid, alloc_wen, alloc_rd,
    output alloc_ready, alloc_roben,
    output Decoded_WP1_Wen, Decoded_WP1_ROBEN, Decoded_WP1_DRindex,
    input  cdb_valid, cdb_roben, cdb_data, cdb_mispredict,
    output WP1_Wen, WP1_ROBEN, WP1_DRindex, WP1_Data, ROB_FLUSH_Flag
  );

endinterface

// File: rtl/rob_commit_unit_rob_ptr.sv
// rob_ptr: wrapping 1..ROB_SIZE tag pointer with increment and clear.
// Clear has priority so a flush always lands the pointer back on tag 1.
module rob_commit_unit_rob_ptr
  import rob_commit_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output tag_t ptr
);

  tag_t ptr_q, ptr_d;

  // Next pointer: clear, advance with wrap, or hold.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = TAG_FIRST;
    end else if (inc) begin
      ptr_d = tag_next(ptr_q);
    end
  end

  // Pointer register; reset points at the first live tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= TAG_FIRST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: hands out tags at decode, captures CDB results and retires
// the head entry in program order through the WP1 commit port. A committing
// mispredicted branch empties the whole buffer and pulses ROB_FLUSH_Flag.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rob_commit_unit_if.slave  bus,
  input  tag_t              rd_roben1,
  input  tag_t              rd_roben2,
  output logic              rd_ready1,
  output logic              rd_ready2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output tag_t              rob_count
);

  rob_entry_t        entries_q [ROB_SIZE];
  rob_entry_t        entries_d [ROB_SIZE];
  tag_t              count_q, count_d;
  logic              wp1_wen_q, wp1_wen_d;
  tag_t              wp1_roben_q, wp1_roben_d;
  logic [RD_W-1:0]   wp1_rd_q, wp1_rd_d;
  logic [DATA_W-1:0] wp1_data_q, wp1_data_d;
  logic              flush_q, flush_d;

  tag_t       head, tail;
  rob_entry_t head_entry;
  logic       alloc_ready, fire, commit_ok, flush_now;

  rob_commit_unit_rob_ptr u_head (
    .clk (clk), .rst (rst), .inc (commit_ok), .clr (flush_now), .ptr (head)
  );

  rob_commit_unit_rob_ptr u_tail (
    .clk (clk), .rst (rst), .inc (fire), .clr (flush_now), .ptr (tail)
  );

  // Allocation handshake; the flush cycle and a full buffer both stall decode.
  assign alloc_ready = (count_q < TAG_LAST) & ~flush_q;
  assign fire        = bus.alloc_valid & alloc_ready;

  assign bus.alloc_ready         = alloc_ready;
  assign bus.alloc_roben         = tail;
  assign bus.Decoded_WP1_Wen     = fire & bus.alloc_wen;
  assign bus.Decoded_WP1_ROBEN   = tail;
  assign bus.Decoded_WP1_DRindex = bus.alloc_rd;

  // Select the head entry; entry i holds tag i+1.
  always_comb begin
    head_entry = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (head == tag_t'(i + 1)) head_entry = entries_q[i];
    end
  end

  assign commit_ok = head_entry.valid & head_entry.ready;
  assign flush_now = commit_ok & head_entry.mispredict;

  // Entry array update: allocate at tail, capture CDB, free head, flush all.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (fire && tail == tag_t'(i + 1)) begin
        entries_d[i]       = '0;
        entries_d[i].valid = 1'b1;
        entries_d[i].wen   = bus.alloc_wen;
        entries_d[i].rd    = bus.alloc_rd;
      end
      if (bus.cdb_valid && bus.cdb_roben == tag_t'(i + 1) && entries_q[i].valid) begin
        entries_d[i].ready      = 1'b1;
        entries_d[i].data       = bus.cdb_data;
        entries_d[i].mispredict = bus.cdb_mispredict;
      end
      if (commit_ok && head == tag_t'(i + 1)) entries_d[i] = '0;
      if (flush_now) entries_d[i] = '0;
    end
  end

  // Occupancy and commit-port next state; commit fields hold when idle.
  always_comb begin
    count_d = count_q;
    if (flush_now) begin
      count_d = '0;
    end else if (fire && !commit_ok) begin
      count_d = count_q + tag_t'(1);
    end else if (!fire && commit_ok) begin
      count_d = count_q - tag_t'(1);
    end

    wp1_wen_d   = commit_ok & head_entry.wen & (head_entry.rd != '0);
    wp1_roben_d = wp1_roben_q;
    wp1_rd_d    = wp1_rd_q;
    wp1_data_d  = wp1_data_q;
    if (commit_ok) begin
      wp1_roben_d = head;
      wp1_rd_d    = head_entry.rd;
      wp1_data_d  = head_entry.data;
    end
    flush_d = flush_now;
  end

  // State registers; reset drops every in-flight entry and silences WP1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      count_q     <= '0;
      wp1_wen_q   <= 1'b0;
      wp1_roben_q <= '0;
      wp1_rd_q    <= '0;
      wp1_data_q  <= '0;
      flush_q     <= 1'b0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= entries_d[i];
      count_q     <= count_d;
      wp1_wen_q   <= wp1_wen_d;
      wp1_roben_q <= wp1_roben_d;
      wp1_rd_q    <= wp1_rd_d;
      wp1_data_q  <= wp1_data_d;
      flush_q     <= flush_d;
    end
  end

  assign bus.WP1_Wen        = wp1_wen_q;
  assign bus.WP1_ROBEN      = wp1_roben_q;
  assign bus.WP1_DRindex    = wp1_rd_q;
  assign bus.WP1_Data       = wp1_data_q;
  assign bus.ROB_FLUSH_Flag = flush_q;
  assign rob_count          = count_q;

  // Operand lookup for rename: a ready entry wins, else a same-cycle CDB hit.
  always_comb begin
    rd_ready1 = 1'b0;
    rd_data1  = '0;
    rd_ready2 = 1'b0;
    rd_data2  = '0;
    if (bus.cdb_valid && rd_roben1 != TAG_NONE && bus.cdb_roben == rd_roben1) begin
      rd_ready1 = 1'b1;
      rd_data1  = bus.cdb_data;
    end
    if (bus.cdb_valid && rd_roben2 != TAG_NONE && bus.cdb_roben == rd_roben2) begin
      rd_ready2 = 1'b1;
      rd_data2  = bus.cdb_data;
    end
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (rd_roben1 == tag_t'(i + 1) && entries_q[i].valid && entries_q[i].ready) begin
        rd_ready1 = 1'b1;
        rd_data1  = entries_q[i].data;
      end
      if (rd_roben2 == tag_t'(i + 1) && entries_q[i].valid && entries_q[i].ready) begin
        rd_ready2 = 1'b1;
        rd_data2  = entries_q[i].data;
      end
    end
  end

endmodule
